pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and PC-sequencing controller for the 5-stage pipeline. Computes next-PC (sequential, jump, taken branch) and drives the stall/flush controls for the PC register, IF/ID and ID/EX. Also sequences multi-cycle multiply/divide operations in EX through a small busy FSM, and keeps a stall-cycle performance counter. Sits beside the datapath: all control outputs are combinational from its inputs plus its internal state.

## Interface
- MDU_LAT, 4, total EX occupancy in cycles of a mult/div op; legal range 2..15
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pc  in  32  current PC register value
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt
- id_jump  in  1  ID holds j/jal/jr
- id_jump_target  in  32  jump target
- ex_memread  in  1  EX holds a load
- ex_rd  in  5  destination register of the EX instruction
- ex_branch_taken  in  1  branch resolved taken in EX
- ex_branch_target  in  32  branch target
- ex_mdu  in  1  EX holds a mult/div op
- npc  out  32  next PC, to the PC register
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  clear IF/ID to bubble
- idex_stall  out  1  hold ID/EX (EX occupied by mult/div)
- idex_flush  out  1  clear ID/EX to bubble
- mdu_busy  out  1  FSM in BUSY
- stall_cycles  out  32  count of cycles with pc_stall=1

## Operation
- Condition terms:
  - load_use = ex_memread & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd))
  - mdu_hold = (IDLE & ex_mdu) | (BUSY & cnt>1)
- Priority, highest first; exactly one applies per cycle:
  1. ex_branch_taken: npc=ex_branch_target; ifid_flush=1, idex_flush=1; no stalls. MDU FSM does not start even if ex_mdu=1.
  2. mdu_hold: pc_stall=ifid_stall=idex_stall=1, all flushes 0; npc=pc+4 (ignored by the PC register).
  3. load_use: pc_stall=ifid_stall=1, idex_flush=1 (bubble into EX), idex_stall=0.
  4. id_jump: npc=id_jump_target, ifid_flush=1, no stall. A jr with a load-use dependency falls under 3 and is re-evaluated next cycle.
  5. Otherwise: npc=pc+4, all controls 0.
- Address arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- MDU FSM, states IDLE and BUSY, with a 4-bit counter cnt:
  - IDLE & ex_mdu & !ex_branch_taken: go to BUSY, cnt=MDU_LAT-1.
  - BUSY & cnt>1: cnt decrements.
  - BUSY & cnt==1: no hold this cycle (op completes, pipeline advances); go to IDLE.
  - Back-to-back mult/div ops: the second op is seen in IDLE the next cycle and restarts the FSM.
  - mdu_busy = (state==BUSY).
- stall_cycles increments on every cycle with pc_stall=1 and wraps from 2^32-1 to 0.

## Timing
- Reset values: state IDLE, cnt=0, stall_cycles=0. With inputs idle after reset: pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush and mdu_busy are all 0, and npc=pc+4.
- Latency: all control outputs and npc are zero-latency, combinational in the same cycle. State and the counter update on the posedge clk.
- A mult/div op occupies EX for exactly MDU_LAT cycles, of which MDU_LAT-1 are stall cycles.
- Load-use inserts exactly 1 stall cycle; on the next cycle the load has left EX, so load_use=0.
- Reset asserted mid-BUSY: FSM goes to IDLE and cnt to 0 immediately (asynchronous); stalls drop in the same cycle; stall_cycles clears.
- No registered output depends on npc.

## Test plan
- Reset, then pc=0x100 with no hazards: npc=0x104 and all controls 0. With pc=0xFFFF_FFFC: npc=0.
- Load-use: ex_memread=1, ex_rd=5, id_rs=5, id_uses_rs=1 → exactly one cycle of pc_stall=ifid_stall=idex_flush=1. With ex_rd=0 → no stall.
- Branch taken with target 0x200 while load_use and id_jump are also true → npc=0x200, ifid_flush=idex_flush=1, pc_stall=0.
- Mult/div with MDU_LAT=4: ex_mdu held high → stall controls high for 3 cycles, mdu_busy high for 3 cycles, released on the 4th cycle; stall_cycles advances by 3. Two consecutive ops → 6 stall cycles total.
- id_jump with target 0x4000, no other hazard → npc=0x4000, ifid_flush=1. Same jump plus load-use on rs → stall first, jump taken on the following cycle.
- Assert rst in the 2nd BUSY cycle → mdu_busy=0, all stalls 0, stall_cycles=0. After release, with ex_mdu=1 a fresh 3-cycle stall starts.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Hazard and PC-sequencing controller for the 5-stage pipeline.
//            Selects the next PC (sequential, jump, taken branch). Drives the
//            stall and flush controls for the PC register, IF/ID and ID/EX.
//            Sequences multi-cycle mult/div ops in EX with an IDLE/BUSY FSM.
//            Counts the cycles in which the PC was held.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   pc                 current PC register value
//   id_rs, id_rt       source registers of the ID instruction
//   id_uses_rs/_rt     ID instruction reads rs / rt
//   id_jump            ID holds j/jal/jr
//   id_jump_target     jump target
//   ex_memread, ex_rd  EX holds a load, and the load's destination register
//   ex_branch_taken    branch resolved taken in EX
//   ex_branch_target   branch target
//   ex_mdu             EX holds a mult/div op
//   npc                next PC, to the PC register
//   pc_stall           hold the PC register
//   ifid_stall         hold IF/ID
//   ifid_flush         clear IF/ID to a bubble
//   idex_stall         hold ID/EX
//   idex_flush         clear ID/EX to a bubble
//   mdu_busy           the mult/div FSM is in BUSY
//   stall_cycles       count of cycles with pc_stall=1 (wraps)
// Parameter
//   MDU_LAT            EX occupancy of a mult/div op in cycles (2..15)
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_jump,
  input  logic [31:0] id_jump_target,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        ex_mdu,
  output logic [31:0] npc,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_stall,
  output logic        idex_flush,
  output logic        mdu_busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // The cycle that starts an op is already its first EX cycle. The counter
  // therefore covers the remaining MDU_LAT-1 cycles.
  localparam logic [3:0] c_cnt_init = 4'(MDU_LAT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [31:0] r_stall_cycles;

  logic [31:0] w_pc_plus4;
  logic        w_rs_hit;
  logic        w_rt_hit;
  logic        w_load_use;
  logic        w_mdu_hold;

  // --------------------------------------------------------------------------
  // Hazard condition terms
  // --------------------------------------------------------------------------
  // The adder is 32 bits wide, so 0xFFFF_FFFC + 4 wraps to 0.
  assign w_pc_plus4 = pc + 32'd4;

  // Register 0 is hard-wired, so a load to r0 never creates a dependency.
  assign w_rs_hit   = id_uses_rs && (id_rs == ex_rd);
  assign w_rt_hit   = id_uses_rt && (id_rt == ex_rd);
  assign w_load_use = ex_memread && (ex_rd != 5'd0) && (w_rs_hit || w_rt_hit);

  // Hold while the op is still running. On the last BUSY cycle (cnt==1) the
  // op completes in this cycle, so the pipeline may advance.
  assign w_mdu_hold = ((r_state == ST_IDLE) && ex_mdu) ||
                      ((r_state == ST_BUSY) && (r_cnt > 4'd1));

  // --------------------------------------------------------------------------
  // MDU FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // MDU FSM next state, and hazard priority resolution
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    npc         = w_pc_plus4;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // A taken branch squashes the op that would otherwise start.
        if (ex_mdu && !ex_branch_taken) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = c_cnt_init;
        end
      end
      ST_BUSY: begin
        if (r_cnt > 4'd1) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          // Last occupancy cycle. A back-to-back op is picked up in IDLE.
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase

    // Exactly one action applies per cycle, highest priority first.
    if (ex_branch_taken) begin
      npc        = ex_branch_target;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_mdu_hold) begin
      // npc keeps pc+4; the PC register ignores it while stalled.
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_stall = 1'b1;
    end else if (w_load_use) begin
      // Freeze the front end and send a bubble into EX. The load moves on, so
      // the dependency clears next cycle. A dependent jr is re-evaluated then.
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end else if (id_jump) begin
      npc        = id_jump_target;
      ifid_flush = 1'b1;
    end
  end

  assign mdu_busy = (r_state == ST_BUSY);

  // --------------------------------------------------------------------------
  // Stall-cycle performance counter; wraps naturally at 2^32
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= 32'd0;
    end else if (pc_stall) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench for pipe_hazard_ctrl. Runs directed scenarios,
//            then randomized traffic, against a cycle-level reference model.
//            The model tracks a mult/div op by its age in cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int MDU_LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [4:0]  id_rs, id_rt;
  logic        id_uses_rs, id_uses_rt;
  logic        id_jump;
  logic [31:0] id_jump_target;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic        ex_mdu;
  logic [31:0] npc;
  logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, mdu_busy;
  logic [31:0] stall_cycles;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_ctrl #(.MDU_LAT(MDU_LAT)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc               (pc),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_uses_rs       (id_uses_rs),
    .id_uses_rt       (id_uses_rt),
    .id_jump          (id_jump),
    .id_jump_target   (id_jump_target),
    .ex_memread       (ex_memread),
    .ex_rd            (ex_rd),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .ex_mdu           (ex_mdu),
    .npc              (npc),
    .pc_stall         (pc_stall),
    .ifid_stall       (ifid_stall),
    .ifid_flush       (ifid_flush),
    .idex_stall       (idex_stall),
    .idex_flush       (idex_flush),
    .mdu_busy         (mdu_busy),
    .stall_cycles     (stall_cycles)
  );

  always #5 clk = ~clk;

  // Control outputs packed for comparison:
  // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, mdu_busy}
  logic [5:0] w_obs_ctrl;
  assign w_obs_ctrl = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, mdu_busy};

  // ---------------------------------------------------------------- model ---
  // Op in flight: m_active is set once the op has spent its first cycle in EX.
  // m_age counts the cycles it has spent in EX so far. The op stalls every
  // cycle except its final cycle (age MDU_LAT-1).
  bit          m_active;
  int          m_age;
  logic [31:0] m_stalls;
  logic [31:0] e_npc;
  logic [5:0]  e_ctrl;

  // Values sampled by the most recent step, for directed literal checks.
  logic [31:0] s_npc;
  logic [5:0]  s_ctrl;
  logic [31:0] s_stalls;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_eval();
    bit lu, mh;
    lu = ex_memread && (ex_rd != 5'd0) &&
         ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    mh = m_active ? (m_age < MDU_LAT - 1) : ex_mdu;
    e_npc  = pc + 32'd4;
    e_ctrl = 6'b0;
    if (ex_branch_taken) begin
      e_npc  = ex_branch_target;
      e_ctrl = 6'b001010;
    end else if (mh) begin
      e_ctrl = 6'b110100;
    end else if (lu) begin
      e_ctrl = 6'b110010;
    end else if (id_jump) begin
      e_npc  = id_jump_target;
      e_ctrl = 6'b001000;
    end
    e_ctrl[0] = m_active;
  endtask

  task automatic model_advance();
    if (e_ctrl[5]) m_stalls = m_stalls + 32'd1;
    if (m_active) begin
      if (m_age == MDU_LAT - 1) m_active = 0;
      else m_age++;
    end else if (ex_mdu && !ex_branch_taken) begin
      m_active = 1;
      m_age    = 1;
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_age    = 0;
    m_stalls = 32'd0;
  endtask

  // Compare one cycle at the negative edge, then advance the model at the
  // positive edge. Inputs stay stable across the whole cycle.
  task automatic step(input string tag);
    @(negedge clk);
    model_eval();
    s_npc    = npc;
    s_ctrl   = w_obs_ctrl;
    s_stalls = stall_cycles;
    check_val({tag, "_npc"},  npc,                 e_npc);
    check_val({tag, "_ctrl"}, {26'd0, w_obs_ctrl}, {26'd0, e_ctrl});
    check_val({tag, "_scnt"}, stall_cycles,        m_stalls);
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_jump = 1'b0; id_jump_target = 32'd0;
    ex_memread = 1'b0; ex_rd = 5'd0;
    ex_branch_taken = 1'b0; ex_branch_target = 32'd0; ex_mdu = 1'b0;
  endtask

  task automatic set_load_use_rs5();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
  endtask

  initial begin : main
    int stall_seen;
    logic [31:0] base;

    rst = 1'b1;
    pc  = 32'h100;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy",   {31'd0, mdu_busy}, 32'd0);
    check_val("rst_scnt",   stall_cycles,      32'd0);
    rst = 1'b0;

    // Sequential fetch and PC wrap.
    step("seq");
    check_val("seq_lit_npc",  s_npc,           32'h104);
    check_val("seq_lit_ctrl", {26'd0, s_ctrl}, 32'd0);
    pc = 32'hFFFF_FFFC;
    step("wrap");
    check_val("wrap_lit_npc", s_npc, 32'h0);
    pc = 32'h100;

    // Load-use for one cycle; the load then leaves EX.
    set_load_use_rs5();
    step("lu");
    check_val("lu_lit_ctrl", {26'd0, s_ctrl}, {26'd0, 6'b110010});
    ex_memread = 1'b0;
    step("lu_after");
    check_val("lu_after_ctrl", {26'd0, s_ctrl}, 32'd0);
    set_load_use_rs5();
    ex_rd = 5'd0; id_rs = 5'd0;
    step("lu_r0");
    check_val("lu_r0_ctrl", {26'd0, s_ctrl}, 32'd0);
    idle_inputs();

    // A taken branch beats both load-use and jump.
    set_load_use_rs5();
    id_jump = 1'b1; id_jump_target = 32'h4000;
    ex_branch_taken = 1'b1; ex_branch_target = 32'h200;
    step("br");
    check_val("br_lit_npc",  s_npc,           32'h200);
    check_val("br_lit_ctrl", {26'd0, s_ctrl}, {26'd0, 6'b001010});
    idle_inputs();

    // Two back-to-back mult/div ops with ex_mdu held high: 6 stalls in 8 cycles.
    base = stall_cycles;
    stall_seen = 0;
    ex_mdu = 1'b1;
    for (int i = 0; i < 2 * MDU_LAT; i++) begin
      step("mdu");
      if (s_ctrl[5]) stall_seen++;
    end
    ex_mdu = 1'b0;
    step("mdu_end");
    check_val("mdu_stall_cnt",  stall_seen,          32'd6);
    check_val("mdu_scnt_delta", stall_cycles - base, 32'd6);

    // Jump alone, then a jump with a load-use dependency on rs.
    id_jump = 1'b1; id_jump_target = 32'h4000;
    step("jmp");
    check_val("jmp_lit_npc", s_npc, 32'h4000);
    set_load_use_rs5();
    step("jmp_lu");
    check_val("jmp_lu_lit_ctrl", {26'd0, s_ctrl}, {26'd0, 6'b110010});
    ex_memread = 1'b0;
    step("jmp_after");
    check_val("jmp_after_npc", s_npc, 32'h4000);
    idle_inputs();

    // Reset during the second BUSY cycle.
    ex_mdu = 1'b1;
    step("rb_start");
    ex_mdu = 1'b0;
    step("rb_busy1");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_val("rb_busy",  {31'd0, mdu_busy}, 32'd0);
    check_val("rb_stall", {29'd0, pc_stall, ifid_stall, idex_stall}, 32'd0);
    check_val("rb_scnt",  stall_cycles,      32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stall_seen = 0;
    ex_mdu = 1'b1;
    for (int i = 0; i < MDU_LAT; i++) begin
      step("rb_fresh");
      if (s_ctrl[5]) stall_seen++;
      ex_mdu = 1'b0;
    end
    check_val("rb_fresh_stalls", stall_seen, 32'd3);

    // Randomized traffic. Small register numbers make hazards frequent.
    for (int i = 0; i < 400; i++) begin
      pc               = {$urandom(), 2'b00} ^ 32'h0;
      id_rs            = 5'($urandom_range(0, 3));
      id_rt            = 5'($urandom_range(0, 3));
      id_uses_rs       = 1'($urandom_range(0, 1));
      id_uses_rt       = 1'($urandom_range(0, 1));
      id_jump          = ($urandom_range(0, 3) == 0);
      id_jump_target   = $urandom();
      ex_memread       = ($urandom_range(0, 2) == 0);
      ex_rd            = 5'($urandom_range(0, 3));
      ex_branch_taken  = ($urandom_range(0, 5) == 0);
      ex_branch_target = $urandom();
      ex_mdu           = ($urandom_range(0, 7) == 0);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
